// File: rtl/bus_enable_sequencer.sv
// Round-robin owner sequencer for line drivers sharing one bus, with a dead gap between owners.
// Define BUS_SEQ_HOLD_LIMIT_EN to compile in the hold-limit watchdog and TIMEOUT pulse.
module bus_enable_sequencer #(
    parameter int unsigned SOURCES     = 4,
    parameter int unsigned DEAD_CYCLES = 2,
    parameter int unsigned HOLD_LIMIT  = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [SOURCES-1:0]         REQ,
    output logic [SOURCES-1:0]         OE_bar,
    output logic [$clog2(SOURCES)-1:0] GNT_ID,
    output logic                       BUS_BUSY,
    output logic                       TIMEOUT
);

    localparam int unsigned IDW       = $clog2(SOURCES);
    localparam logic [3:0]  DEAD_LAST = 4'(DEAD_CYCLES - 1);

    if (SOURCES < 2 || SOURCES > 8 || DEAD_CYCLES < 1 || DEAD_CYCLES > 15 ||
        HOLD_LIMIT < 1 || HOLD_LIMIT > 255) begin : g_bad_params
        $error("bus_enable_sequencer: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DEAD
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [SOURCES-1:0] r_oe_bar, w_oe_bar_nxt;
    logic [IDW-1:0]     r_gnt_id, w_gnt_id_nxt;
    logic [IDW-1:0]     r_ptr, w_ptr_nxt;
    logic               r_busy, w_busy_nxt;
    logic [3:0]         r_dead_cnt, w_dead_cnt_nxt;
    logic [IDW-1:0]     w_win, w_win_inc;
    logic               w_found, w_grant, w_release;

    // Round-robin search starting at r_ptr and wrapping SOURCES-1 -> 0.
    always_comb begin : p_arb
        logic [IDW-1:0] v_idx;
        w_found = 1'b0;
        w_win   = '0;
        v_idx   = r_ptr;
        for (int unsigned i = 0; i < SOURCES; i++) begin
            if (!w_found && REQ[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
            v_idx = (v_idx == IDW'(SOURCES - 1)) ? '0 : v_idx + 1'b1;
        end
        w_win_inc = (w_win == IDW'(SOURCES - 1)) ? '0 : w_win + 1'b1;
    end

`ifdef BUS_SEQ_HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_LIMIT - 1);
    logic [7:0] r_hold_cnt, w_hold_cnt_nxt;
    logic       r_timeout, w_timeout_nxt;
`endif

    always_comb begin : p_fsm
        w_state_nxt    = r_state;
        w_oe_bar_nxt   = r_oe_bar;
        w_gnt_id_nxt   = r_gnt_id;
        w_busy_nxt     = r_busy;
        w_ptr_nxt      = r_ptr;
        w_dead_cnt_nxt = r_dead_cnt;
        w_grant        = 1'b0;
        w_release      = 1'b0;
`ifdef BUS_SEQ_HOLD_LIMIT_EN
        w_hold_cnt_nxt = r_hold_cnt;
        w_timeout_nxt  = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: w_grant = w_found;
            S_DRIVE: begin
                if (!REQ[r_gnt_id]) begin
                    w_release = 1'b1;
`ifdef BUS_SEQ_HOLD_LIMIT_EN
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_release     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
`endif
                end
            end
            S_DEAD: begin
                // Requests are only looked at on the last dead edge.
                if (r_dead_cnt == DEAD_LAST) begin
                    if (w_found) w_grant = 1'b1;
                    else         w_state_nxt = S_IDLE;
                end else begin
                    w_dead_cnt_nxt = r_dead_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_grant) begin
            w_state_nxt  = S_DRIVE;
            w_oe_bar_nxt = ~(SOURCES'(1) << w_win);
            w_gnt_id_nxt = w_win;
            w_busy_nxt   = 1'b1;
            w_ptr_nxt    = w_win_inc;
`ifdef BUS_SEQ_HOLD_LIMIT_EN
            w_hold_cnt_nxt = '0;
`endif
        end
        if (w_release) begin
            w_state_nxt    = S_DEAD;
            w_oe_bar_nxt   = '1;
            w_gnt_id_nxt   = '0;
            w_busy_nxt     = 1'b0;
            w_dead_cnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_oe_bar   <= '1;
            r_gnt_id   <= '0;
            r_busy     <= 1'b0;
            r_ptr      <= '0;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_oe_bar   <= w_oe_bar_nxt;
            r_gnt_id   <= w_gnt_id_nxt;
            r_busy     <= w_busy_nxt;
            r_ptr      <= w_ptr_nxt;
            r_dead_cnt <= w_dead_cnt_nxt;
        end
    end

`ifdef BUS_SEQ_HOLD_LIMIT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end
    assign TIMEOUT = r_timeout;
`else
    assign TIMEOUT = 1'b0;
`endif

    assign OE_bar   = r_oe_bar;
    assign GNT_ID   = r_gnt_id;
    assign BUS_BUSY = r_busy;

endmodule

// File: tb/tb_bus_enable_sequencer.sv
// Directed bench for bus_enable_sequencer (SOURCES=4, DEAD_CYCLES=2, HOLD_LIMIT=16).
// Observed vector packs {OE_bar, GNT_ID, BUS_BUSY, TIMEOUT}.
module tb_bus_enable_sequencer;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] OE_bar;
    logic [1:0] GNT_ID;
    logic       BUS_BUSY;
    logic       TIMEOUT;
    logic [7:0] w_obs;
    logic [7:0] want;
    int         total;
    int         bad;

    bus_enable_sequencer #(
        .SOURCES    (4),
        .DEAD_CYCLES(2),
        .HOLD_LIMIT (16)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ     (REQ),
        .OE_bar  (OE_bar),
        .GNT_ID  (GNT_ID),
        .BUS_BUSY(BUS_BUSY),
        .TIMEOUT (TIMEOUT)
    );

    assign w_obs = {OE_bar, GNT_ID, BUS_BUSY, TIMEOUT};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = 4'b0000;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        REQ = 4'b0101;
        tick();
        tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL reset_state: got %b want %b", w_obs, want); end
    endtask

    task automatic test_single_grant();
        RST = 1'b0;
        REQ = 4'b0001;
        tick();
        want = 8'b1110_00_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL single_first_edge: got %b want %b", w_obs, want); end
        tick(); tick(); tick();
        want = 8'b1110_00_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL single_hold: got %b want %b", w_obs, want); end
        REQ = 4'b0000;
        tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL single_release: got %b want %b", w_obs, want); end
        tick(); tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL single_dead_end: got %b want %b", w_obs, want); end
        REQ = 4'b0010;
        tick();
        want = 8'b1101_01_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL idle_regrant: got %b want %b", w_obs, want); end
        REQ = 4'b0000;
        tick(); tick(); tick();
    endtask

    task automatic test_handover();
        do_reset();
        REQ = 4'b0001;
        tick();
        REQ = 4'b1111;
        tick(); tick();
        want = 8'b1110_00_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL no_preempt: got %b want %b", w_obs, want); end
        REQ = 4'b1110;
        tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL handover_dead_k: got %b want %b", w_obs, want); end
        tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL handover_dead_k1: got %b want %b", w_obs, want); end
        tick();
        want = 8'b1101_01_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL handover_grant: got %b want %b", w_obs, want); end
    endtask

    task automatic test_round_robin();
        logic [1:0] e;
        do_reset();
        REQ = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            e = 2'(n % 4);
            for (int c = 0; c < 3; c++) begin
                want = {~(4'b0001 << e), e, 1'b1, 1'b0}; total++;
                if (w_obs !== want) begin bad++; $display("FAIL rr_grant%0d_c%0d: got %b want %b", n, c, w_obs, want); end
                total++;
                if ($countones(~OE_bar) > 1) begin bad++; $display("FAIL rr_one_low: got oe=%b want at most one low bit", OE_bar); end
                if (c < 2) tick();
            end
            REQ = 4'b1111 & ~(4'b0001 << e);
            tick();
            want = 8'b1111_00_0_0; total++;
            if (w_obs !== want) begin bad++; $display("FAIL rr_dead1_%0d: got %b want %b", n, w_obs, want); end
            REQ = 4'b1111;
            tick();
            want = 8'b1111_00_0_0; total++;
            if (w_obs !== want) begin bad++; $display("FAIL rr_dead2_%0d: got %b want %b", n, w_obs, want); end
            tick();
        end
    endtask

    task automatic test_dead_window();
        do_reset();
        REQ = 4'b0001;
        tick();
        REQ = 4'b0011;
        tick();
        REQ = 4'b0000;
        tick();
        REQ = 4'b0010;
        tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL dead_ignores_mid_req: got %b want %b", w_obs, want); end
        REQ = 4'b0100;
        tick();
        want = 8'b1011_10_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL dead_final_eval: got %b want %b", w_obs, want); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        REQ = 4'b0100;
        tick();
        want = 8'b1011_10_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL rst_setup_owner2: got %b want %b", w_obs, want); end
        RST = 1'b1;
        tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL rst_mid_drive: got %b want %b", w_obs, want); end
        RST = 1'b0;
        REQ = 4'b1001;
        tick();
        want = 8'b1110_00_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL rst_ptr_cleared: got %b want %b", w_obs, want); end
        REQ = 4'b0000;
        tick();
        RST = 1'b1;
        tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL rst_mid_dead: got %b want %b", w_obs, want); end
        RST = 1'b0;
        REQ = 4'b1000;
        tick();
        want = 8'b0111_11_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL rst_wrap_to_3: got %b want %b", w_obs, want); end
    endtask

    task automatic test_hold();
        do_reset();
        REQ = 4'b0001;
        tick();
`ifdef BUS_SEQ_HOLD_LIMIT_EN
        for (int i = 0; i < 16; i++) begin
            want = 8'b1110_00_1_0; total++;
            if (w_obs !== want) begin bad++; $display("FAIL hold_drive_%0d: got %b want %b", i, w_obs, want); end
            if (i < 15) tick();
        end
        tick();
        want = 8'b1111_00_0_1; total++;
        if (w_obs !== want) begin bad++; $display("FAIL hold_timeout: got %b want %b", w_obs, want); end
        tick();
        want = 8'b1111_00_0_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL hold_dead2: got %b want %b", w_obs, want); end
        tick();
        want = 8'b1110_00_1_0; total++;
        if (w_obs !== want) begin bad++; $display("FAIL hold_regrant: got %b want %b", w_obs, want); end
`else
        for (int i = 0; i < 100; i++) begin
            want = 8'b1110_00_1_0; total++;
            if (w_obs !== want) begin bad++; $display("FAIL unbounded_%0d: got %b want %b", i, w_obs, want); end
            tick();
        end
`endif
        REQ = 4'b0000;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        REQ   = 4'b0000;
        test_reset();
        test_single_grant();
        test_handover();
        test_round_robin();
        test_dead_window();
        test_reset_mid();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
